// File: rtl/output_port_arbiter_pkg.sv
// output_port_arbiter_pkg: shared widths, port indices, state encodings and default timeout
package output_port_arbiter_pkg;
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int NUM_PORTS = 5;
  localparam int DEF_TIMEOUT = 255;
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCKED = 1'b1;
endpackage

// File: rtl/output_port_arbiter_rr_priority_select.sv
// output_port_arbiter_rr_priority_select: one-hot first requester searching upward from ptr with wrap
module output_port_arbiter_rr_priority_select #(
  parameter int N = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);
  logic [N-1:0] hi;
  always_comb begin
    hi = req & ~((N'(1) << ptr) - N'(1));
    win = (|hi) ? (hi & (~hi + N'(1))) : (req & (~req + N'(1)));
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter for one router output port; ARB_TIMEOUT_EN adds forced lock release
module output_port_arbiter #(
  parameter int NUM_PORTS = output_port_arbiter_pkg::NUM_PORTS,
  parameter int DATA_WIDTH = output_port_arbiter_pkg::DATA_WIDTH,
  parameter int TIMEOUT = output_port_arbiter_pkg::DEF_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            tail,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic                            ready_in,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            buf_en,
  output logic [DATA_WIDTH-1:0]           buf_data,
  output logic                            timeout_err
);
  import output_port_arbiter_pkg::*;
  localparam int PW = $clog2(NUM_PORTS);
  logic state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d, win;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, next_ptr;
  logic timeout_err_q, timeout_err_d;
  logic fire, last, to, rel;
  output_port_arbiter_rr_priority_select #(.N(NUM_PORTS), .PW(PW)) u_sel (
    .req(req),
    .ptr(rr_ptr_q),
    .win(win)
  );
`ifdef ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  always_comb begin
    to = state_q == ST_LOCKED && !fire && stall_q == SW'(TIMEOUT - 1);
    stall_d = (state_q == ST_LOCKED && !fire && !to) ? stall_q + SW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    stall_q <= rst ? '0 : stall_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to = 1'b0;
`endif
  always_comb begin
    fire = state_q == ST_LOCKED && |(req & grant_q) && ready_in;
    last = fire && |(tail & grant_q);
    rel = last || to;
    next_ptr = '0;
    buf_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      next_ptr = grant_q[i] ? PW'((i + 1) % NUM_PORTS) : next_ptr;
      buf_data = buf_data | (data_in[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
    end
    ack = fire ? grant_q : '0;
    buf_en = fire;
    state_d = (state_q == ST_IDLE) ? (|req ? ST_LOCKED : ST_IDLE) : (rel ? ST_IDLE : ST_LOCKED);
    grant_d = (state_q == ST_IDLE) ? win : (rel ? '0 : grant_q);
    rr_ptr_d = rel ? next_ptr : rr_ptr_q;
    timeout_err_d = to;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? ST_IDLE : state_d;
    grant_q <= rst ? '0 : grant_d;
    rr_ptr_q <= rst ? '0 : rr_ptr_d;
    timeout_err_q <= rst ? 1'b0 : timeout_err_d;
  end
  assign grant = grant_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed vector table plus reset, fairness and stall/timeout sequences
module tb_output_port_arbiter;
  import output_port_arbiter_pkg::*;
  typedef struct {
    logic [4:0]  req;
    logic [4:0]  tail;
    logic [23:0] d;
    logic        rdy;
    logic [4:0]  eg;
    logic [4:0]  ea;
    logic        eb;
    logic [31:0] ed;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] tail = '0;
  logic [23:0] d = '0;
  logic ready_in = 1'b1;
  logic [159:0] data_in;
  logic [4:0] ack, grant;
  logic buf_en, timeout_err;
  logic [31:0] buf_data;
  int n_cmp = 0;
  int n_fail = 0;
  vec_t tv[$];
  int order[5] = '{PORT_N, PORT_E, PORT_S, PORT_W, PORT_L};
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < 5; i++) data_in[i*32 +: 32] = {8'(i), d};
  end
  output_port_arbiter #(.NUM_PORTS(5), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .tail(tail),
    .data_in(data_in),
    .ready_in(ready_in),
    .ack(ack),
    .grant(grant),
    .buf_en(buf_en),
    .buf_data(buf_data),
    .timeout_err(timeout_err)
  );
  function automatic vec_t mk(logic [4:0] rq, logic [4:0] tl, logic [23:0] dd, logic rd,
                              logic [4:0] eg, logic [4:0] ea, logic eb, logic [31:0] ed);
    vec_t v;
    v.req = rq; v.tail = tl; v.d = dd; v.rdy = rd;
    v.eg = eg; v.ea = ea; v.eb = eb; v.ed = ed;
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(string tag, logic [4:0] eg, logic [4:0] ea, logic eb, logic [31:0] ed);
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    chk({tag, " ack"}, 32'(ack), 32'(ea));
    chk({tag, " buf_en"}, 32'(buf_en), 32'(eb));
    chk({tag, " buf_data"}, buf_data, ed);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tail = '0;
    ready_in = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tv.push_back(mk(5'b00100, 5'b00000, 24'hA1, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b00100, 5'b00000, 24'hA1, 1, 5'b00100, 5'b00100, 1, 32'h020000A1));
    tv.push_back(mk(5'b00100, 5'b00000, 24'hA2, 1, 5'b00100, 5'b00100, 1, 32'h020000A2));
    tv.push_back(mk(5'b00100, 5'b00100, 24'hA3, 1, 5'b00100, 5'b00100, 1, 32'h020000A3));
    tv.push_back(mk(5'b00000, 5'b00000, 24'hA3, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b00010, 5'b00000, 24'hB1, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b00010, 5'b00000, 24'hB1, 1, 5'b00010, 5'b00010, 1, 32'h010000B1));
    for (int k = 0; k < 4; k++)
      tv.push_back(mk(5'b00010, 5'b00000, 24'hB2, 0, 5'b00010, 5'b00000, 0, 32'h010000B2));
    tv.push_back(mk(5'b00010, 5'b00000, 24'hB2, 1, 5'b00010, 5'b00010, 1, 32'h010000B2));
    tv.push_back(mk(5'b10101, 5'b00000, 24'hB3, 1, 5'b00010, 5'b00000, 0, 32'h010000B3));
    tv.push_back(mk(5'b00010, 5'b00010, 24'hB3, 1, 5'b00010, 5'b00010, 1, 32'h010000B3));
    tv.push_back(mk(5'b00000, 5'b00000, 24'h00, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b01000, 5'b00000, 24'hC1, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b01001, 5'b00000, 24'hC1, 1, 5'b01000, 5'b01000, 1, 32'h030000C1));
    tv.push_back(mk(5'b01001, 5'b00000, 24'hC2, 1, 5'b01000, 5'b01000, 1, 32'h030000C2));
    tv.push_back(mk(5'b01001, 5'b01000, 24'hC3, 1, 5'b01000, 5'b01000, 1, 32'h030000C3));
    tv.push_back(mk(5'b10001, 5'b00000, 24'hD1, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b10001, 5'b10000, 24'hD1, 1, 5'b10000, 5'b10000, 1, 32'h040000D1));
    tv.push_back(mk(5'b00001, 5'b00001, 24'hE1, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tv.push_back(mk(5'b00001, 5'b00001, 24'hE1, 1, 5'b00001, 5'b00001, 1, 32'h000000E1));
    tv.push_back(mk(5'b00000, 5'b00000, 24'h00, 1, 5'b00000, 5'b00000, 0, 32'h0));
    tick();
    tick();
    @(negedge clk);
    chk_all("reset", 5'b0, 5'b0, 1'b0, 32'h0);
    chk("reset timeout_err", 32'(timeout_err), 32'h0);
    tick();
    rst = 1'b0;
    foreach (tv[i]) begin
      req = tv[i].req;
      tail = tv[i].tail;
      d = tv[i].d;
      ready_in = tv[i].rdy;
      @(negedge clk);
      chk_all($sformatf("v%0d", i), tv[i].eg, tv[i].ea, tv[i].eb, tv[i].ed);
      tick();
    end
    req = 5'b00100;
    tail = '0;
    d = 24'hF0;
    ready_in = 1'b1;
    tick();
    @(negedge clk);
    chk_all("midpkt header", 5'b00100, 5'b00100, 1'b1, 32'h020000F0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_all("midpkt reset", 5'b0, 5'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    req = 5'b00101;
    tail = 5'b00101;
    tick();
    @(negedge clk);
    chk("post-reset winner", 32'(grant), 32'(5'b1 << PORT_N));
    chk("post-reset ack", 32'(ack), 32'(5'b1 << PORT_N));
    tick();
    do_reset();
    req = 5'b11111;
    tail = 5'b11111;
    d = 24'h0000F0;
    for (int k = 0; k < 10; k++) begin
      logic [4:0] eg;
      eg = 5'b00001 << order[k % 5];
      @(negedge clk);
      chk($sformatf("rr%0d gap grant", k), 32'(grant), 32'h0);
      chk($sformatf("rr%0d gap buf_en", k), 32'(buf_en), 32'h0);
      tick();
      @(negedge clk);
      chk_all($sformatf("rr%0d", k), eg, eg, 1'b1, {8'(order[k % 5]), 24'h0000F0});
      tick();
    end
    do_reset();
    req = 5'b00010;
    tail = '0;
    d = 24'h000077;
    tick();
    @(negedge clk);
    chk_all("to header", 5'b00010, 5'b00010, 1'b1, 32'h01000077);
    tick();
    req = 5'b00101;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      chk_all($sformatf("stall%0d", s), 5'b00010, 5'b0, 1'b0, 32'h01000077);
      chk($sformatf("stall%0d timeout_err", s), 32'(timeout_err), 32'h0);
      tick();
    end
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    chk("to release grant", 32'(grant), 32'h0);
    chk("to pulse", 32'(timeout_err), 32'h1);
`else
    chk("hold grant", 32'(grant), 32'(5'b00010));
    chk("no pulse", 32'(timeout_err), 32'h0);
`endif
    tick();
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    chk("to next grant", 32'(grant), 32'(5'b1 << PORT_S));
`else
    chk("still held", 32'(grant), 32'(5'b00010));
`endif
    chk("pulse once", 32'(timeout_err), 32'h0);
    chk("stall ack", 32'(ack & ~grant), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
